ssi_sfifo_gen2: RTL

//  Single-clock, parametrised synchronous FIFO; successor to the first-generation sfifo.

---
 rtl/ssi_sfifo_gen2_if.sv | 36 +++
 rtl/ssi_sfifo_gen2.sv | 95 +++++++++
 2 files changed

// File: rtl/ssi_sfifo_gen2_if.sv
// ssi_sfifo_gen2_if
//   Bundles the producer/consumer side of the ssi_sfifo_gen2 FIFO.
//   master modport : the user of the FIFO (drives data/wrreq/rdreq/clr_err)
//   slave modport  : the FIFO itself (drives q, usedw and all status flags)
//   Signals:
//     data, wrreq    push side
//     rdreq, q       pop side
//     clr_err        clears the sticky overflow/underflow flags
//     usedw, full, empty, almost_full, almost_empty, overflow, underflow  status
interface ssi_sfifo_gen2_if #(
  parameter int WIDTH = 32,
  parameter int DLOG2 = 3
);
  logic [WIDTH-1:0] data;
  logic             wrreq;
  logic             rdreq;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [DLOG2:0]   usedw;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output data, wrreq, rdreq, clr_err,
    input  q, usedw, full, empty, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  data, wrreq, rdreq, clr_err,
    output q, usedw, full, empty, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/ssi_sfifo_gen2.sv
// ssi_sfifo_gen2
//   Single-clock synchronous FIFO with arbitrary (non power-of-2) depth,
//   true fill count, guarded push/pop, almost flags and sticky error flags.
//   Ports:
//     clock   system clock, everything on the rising edge
//     sclr_n  synchronous active-low reset
//     bus     ssi_sfifo_gen2_if.slave: data/wrreq/rdreq/clr_err in,
//             q/usedw/full/empty/almost_full/almost_empty/overflow/underflow out
//   Build option:
//     SSI_SFIFO_SHOWAHEAD_EN  when defined, q shows the head word combinationally
//                             and rdreq consumes it; otherwise q is registered
//                             with one cycle of read latency.
module ssi_sfifo_gen2 #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int DLOG2  = 3,
  parameter int AFULL  = 6,
  parameter int AEMPTY = 1
) (
  input logic             clock,
  input logic             sclr_n,
  ssi_sfifo_gen2_if.slave bus
);

  localparam logic [DLOG2:0]   DEPTH_C  = (DLOG2+1)'(DEPTH);
  localparam logic [DLOG2:0]   AFULL_C  = (DLOG2+1)'(AFULL);
  localparam logic [DLOG2:0]   AEMPTY_C = (DLOG2+1)'(AEMPTY);
  localparam logic [DLOG2-1:0] LAST_PTR = DLOG2'(DEPTH - 1);

  logic [WIDTH-1:0] ram [0:DEPTH-1];
  logic [DLOG2-1:0] wr_ptr;
  logic [DLOG2-1:0] rd_ptr;
  logic [DLOG2:0]   count;
  logic             overflow_r;
  logic             underflow_r;
  logic             empty_i;
  logic             full_i;
  logic             rd_ok;
  logic             wr_ok;

  assign empty_i = (count == '0);
  assign full_i  = (count == DEPTH_C);

  // A pop frees a slot in the same edge, so a push on a full FIFO is legal
  // when the pop alongside it is accepted.
  assign rd_ok = bus.rdreq & ~empty_i;
  assign wr_ok = bus.wrreq & (~full_i | rd_ok);

  // Pointers, count and sticky flags. A flag being set beats clr_err.
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (wr_ok && !rd_ok)      count <= count + 1'b1;
      else if (rd_ok && !wr_ok) count <= count - 1'b1;
      overflow_r  <= (overflow_r  & ~bus.clr_err) | (bus.wrreq & ~wr_ok);
      underflow_r <= (underflow_r & ~bus.clr_err) | (bus.rdreq & empty_i);
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (sclr_n && wr_ok) ram[wr_ptr] <= bus.data;
  end

`ifdef SSI_SFIFO_SHOWAHEAD_EN
  // Head word is always presented; meaningless while empty.
  assign bus.q = ram[rd_ptr];
`else
  logic [WIDTH-1:0] q_r;

  // Registered read: q updates only on an accepted pop.
  always_ff @(posedge clock) begin
    if (!sclr_n)    q_r <= '0;
    else if (rd_ok) q_r <= ram[rd_ptr];
  end

  assign bus.q = q_r;
`endif

  assign bus.usedw        = count;
  assign bus.empty        = empty_i;
  assign bus.full         = full_i;
  assign bus.almost_full  = (count >= AFULL_C);
  assign bus.almost_empty = (count <= AEMPTY_C);
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule
